// File: rtl/pipe_fetch_ctrl_if.sv
// Purpose : Bundles the fetch stage's memory handshake, branch redirect,
//           and ID-side signals into one port.
// Signals : imem_req/imem_addr/imem_ack/inst_in  - instruction memory side
//           br_taken/br_target                   - redirect from EX
//           id_stall/inst/if_valid               - hand-off to ID
//           pc/wpcir/fetch_cnt                   - status outputs
// Modports: master = fetch controller, slave = surrounding pipeline/memory.
interface pipe_fetch_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             imem_req;
    logic [31:0]      imem_addr;
    logic             imem_ack;
    logic [31:0]      inst_in;
    logic             br_taken;
    logic [31:0]      br_target;
    logic             id_stall;
    logic [31:0]      inst;
    logic             if_valid;
    logic [31:0]      pc;
    logic             wpcir;
    logic [CNT_W-1:0] fetch_cnt;

    modport master (
        output imem_req, imem_addr, inst, if_valid, pc, wpcir, fetch_cnt,
        input  imem_ack, inst_in, br_taken, br_target, id_stall
    );

    modport slave (
        input  imem_req, imem_addr, inst, if_valid, pc, wpcir, fetch_cnt,
        output imem_ack, inst_in, br_taken, br_target, id_stall
    );
endinterface

// File: rtl/pipe_fetch_ctrl.sv
// Purpose : Instruction-fetch controller. Issues word-aligned fetches,
//           holds a single-entry instruction buffer toward ID, applies
//           branch redirects with flush, and drains a fetch that is still
//           in flight when a redirect arrives.
// Ports   : clk   - rising-edge clock
//           clrn  - asynchronous active-low reset
//           bus   - pipe_fetch_ctrl_if.master (see interface for signals)
// Notes   : imem_req and wpcir are decoded from the current state and
//           inputs (they must react to id_stall / br_taken in the same
//           cycle); every other output is a flop.
module pipe_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic              clk,
    input  logic              clrn,
    pipe_fetch_ctrl_if.master bus
);

    localparam int unsigned     XLEN    = 32;
    localparam logic [XLEN-1:0] PC_INIT = RESET_PC & ~XLEN'(3);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [XLEN-1:0]   pc_q, pc_n;
    logic [XLEN-1:0]   addr_q, addr_n;
    logic [XLEN-1:0]   inst_q, inst_n;
    logic              valid_q, valid_n;
    logic              held_q, held_n;
    logic [CNT_W-1:0]  cnt_q, cnt_n;
    logic              req_c, wpcir_c;
    logic              free, consume;
    logic [XLEN-1:0]   br_pc;

    // State and datapath registers
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state   <= IDLE;
            pc_q    <= PC_INIT;
            addr_q  <= PC_INIT;
            inst_q  <= '0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state   <= state_n;
            pc_q    <= pc_n;
            addr_q  <= addr_n;
            inst_q  <= inst_n;
            valid_q <= valid_n;
            held_q  <= held_n;
            cnt_q   <= cnt_n;
        end
    end

    // Next-state, datapath next values and decoded outputs
    always_comb begin
        state_n = state;
        pc_n    = pc_q;
        addr_n  = addr_q;
        inst_n  = inst_q;
        valid_n = valid_q;
        held_n  = 1'b0;
        cnt_n   = cnt_q;
        req_c   = 1'b0;
        wpcir_c = 1'b0;
        free    = !valid_q || !bus.id_stall;
        consume = valid_q && !bus.id_stall;
        br_pc   = bus.br_target & ~XLEN'(3);

        // A consume is counted even when a redirect flushes the buffer
        // behind it; flushed entries never reach consume, so never count.
        if (consume && (cnt_q != CNT_MAX)) begin
            cnt_n = cnt_q + CNT_W'(1);
        end

        unique case (state)
            IDLE: begin
                state_n = FETCH;
            end

            FETCH: begin
                // A started request stays up until acked, even if ID stalls.
                // A held request always has an empty buffer behind it, so
                // its ack can never overwrite an unconsumed instruction.
                req_c  = held_q || free;
                held_n = req_c && !bus.imem_ack;
                if (bus.br_taken) begin
                    pc_n    = br_pc;
                    wpcir_c = 1'b1;
                    valid_n = 1'b0;
                    if (held_n) begin
                        state_n = DRAIN;
                    end else begin
                        addr_n = br_pc;
                    end
                end else if (req_c && bus.imem_ack) begin
                    inst_n  = bus.inst_in;
                    valid_n = 1'b1;
                    pc_n    = pc_q + XLEN'(4);
                    addr_n  = pc_q + XLEN'(4);
                    wpcir_c = 1'b1;
                end else if (consume) begin
                    valid_n = 1'b0;
                end
            end

            DRAIN: begin
                // Finish the stale request at its old address, drop its data.
                req_c  = 1'b1;
                held_n = !bus.imem_ack;
                if (bus.br_taken) begin
                    pc_n    = br_pc;
                    wpcir_c = 1'b1;
                    valid_n = 1'b0;
                end
                // Ack ends the drain; a redirect in the same cycle still
                // supplies the address of the next request.
                if (bus.imem_ack) begin
                    state_n = FETCH;
                    addr_n  = pc_n;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign bus.imem_req  = req_c;
    assign bus.imem_addr = addr_q;
    assign bus.inst      = inst_q;
    assign bus.if_valid  = valid_q;
    assign bus.pc        = pc_q;
    assign bus.wpcir     = wpcir_c;
    assign bus.fetch_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_fetch_ctrl.sv
// Purpose : Self-checking bench for pipe_fetch_ctrl. Directed stimulus pushes
//           expected ack addresses and consumed instructions into queues; a
//           negedge monitor pops and compares them. A second small instance
//           (CNT_W=2, unaligned RESET_PC) free-runs to exercise saturation.
module tb_pipe_fetch_ctrl;

    logic clk;
    logic clrn;
    logic ack_tie;
    logic ack_raw;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_addr[$];
    logic [31:0] exp_inst[$];

    pipe_fetch_ctrl_if #(.CNT_W(16)) bus ();
    pipe_fetch_ctrl_if #(.CNT_W(2))  bus2 ();

    pipe_fetch_ctrl #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus.master)
    );

    pipe_fetch_ctrl #(.RESET_PC(32'h0000_1003), .CNT_W(2)) dut_sat (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus2.master)
    );

    // Memory model: data is a tag plus the fetched address
    assign bus.imem_ack  = ack_tie ? bus.imem_req : ack_raw;
    assign bus.inst_in   = {8'hC3, bus.imem_addr[23:0]};
    assign bus2.imem_ack = bus2.imem_req;
    assign bus2.inst_in  = {8'hC3, bus2.imem_addr[23:0]};
    assign bus2.br_taken  = 1'b0;
    assign bus2.br_target = 32'h0;
    assign bus2.id_stall  = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] iw(input logic [31:0] a);
        return {8'hC3, a[23:0]};
    endfunction

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset(input string tag);
        check({tag, "_req"},   32'(bus.imem_req),  32'h0);
        check({tag, "_addr"},  bus.imem_addr,      32'h0);
        check({tag, "_inst"},  bus.inst,           32'h0);
        check({tag, "_valid"}, 32'(bus.if_valid),  32'h0);
        check({tag, "_pc"},    bus.pc,             32'h0);
        check({tag, "_wpcir"}, 32'(bus.wpcir),     32'h0);
        check({tag, "_cnt"},   32'(bus.fetch_cnt), 32'h0);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (clrn) begin
            if (bus.imem_req && bus.imem_ack) begin
                if (exp_addr.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL ack_addr: unexpected ack at %h", bus.imem_addr);
                end else begin
                    check("ack_addr", bus.imem_addr, exp_addr.pop_front());
                end
            end
            if (bus.if_valid && !bus.id_stall) begin
                if (exp_inst.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL consume: unexpected inst %h", bus.inst);
                end else begin
                    check("consume_inst", bus.inst, exp_inst.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clrn          = 1'b0;
        ack_tie       = 1'b0;
        ack_raw       = 1'b0;
        bus.id_stall  = 1'b0;
        bus.br_taken  = 1'b0;
        bus.br_target = 32'h0;
        repeat (2) cyc();
        #1;
        chk_reset("rst");
        check("sat_rst_pc",   bus2.pc,        32'h0000_1000);
        check("sat_rst_addr", bus2.imem_addr, 32'h0000_1000);

        // Streaming at zero wait states
        for (int i = 0; i < 5; i++) begin
            exp_addr.push_back(32'(4 * i));
            exp_inst.push_back(iw(32'(4 * i)));
        end
        clrn    = 1'b1;
        ack_tie = 1'b1;
        #1 check("c1_req", 32'(bus.imem_req), 32'h0);
        cyc();
        check("c2_req",   32'(bus.imem_req), 32'h1);
        check("c2_addr",  bus.imem_addr,     32'h0);
        check("c2_valid", 32'(bus.if_valid), 32'h0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("str_valid", 32'(bus.if_valid),  32'h1);
            check("str_inst",  bus.inst,           iw(32'(4 * i)));
            check("str_pc",    bus.pc,             32'(4 * (i + 1)));
            check("str_cnt",   32'(bus.fetch_cnt), 32'(i));
        end

        // ID stall for 5 cycles: buffer held, no new fetch, count frozen
        cyc();
        check("c7_cnt", 32'(bus.fetch_cnt), 32'h4);
        check("c7_pc",  bus.pc,             32'h14);
        bus.id_stall = 1'b1;
        #1 check("stall_req0", 32'(bus.imem_req), 32'h0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("stall_inst",  bus.inst,           iw(32'h10));
            check("stall_valid", 32'(bus.if_valid),  32'h1);
            check("stall_req",   32'(bus.imem_req),  32'h0);
            check("stall_cnt",   32'(bus.fetch_cnt), 32'h4);
            check("sat_cnt",     32'(bus2.fetch_cnt), 32'h3);
        end

        // Ack delayed: request held at 0x14 for 3 cycles
        cyc();
        bus.id_stall = 1'b0;
        ack_tie      = 1'b0;
        ack_raw      = 1'b0;
        exp_addr.push_back(32'h14);
        exp_inst.push_back(iw(32'h14));
        for (int i = 0; i < 3; i++) begin
            if (i == 2) ack_raw = 1'b1;
            #1;
            check("wait_req",   32'(bus.imem_req), 32'h1);
            check("wait_addr",  bus.imem_addr,     32'h14);
            check("wait_pc",    bus.pc,            32'h14);
            check("wait_wpcir", 32'(bus.wpcir),    32'(i == 2));
            if (i > 0) check("wait_valid", 32'(bus.if_valid), 32'h0);
            if (i < 2) cyc();
        end
        cyc();
        ack_raw = 1'b0;
        #1;
        check("c15_pc",    bus.pc,            32'h18);
        check("c15_inst",  bus.inst,          iw(32'h14));
        check("c15_valid", 32'(bus.if_valid), 32'h1);
        check("c15_addr",  bus.imem_addr,     32'h18);

        // Redirect with a request pending: drain the stale fetch
        exp_addr.push_back(32'h18);
        exp_addr.push_back(32'h100);
        cyc();
        bus.br_taken  = 1'b1;
        bus.br_target = 32'h103;
        #1;
        check("br_wpcir", 32'(bus.wpcir),     32'h1);
        check("br_cnt",   32'(bus.fetch_cnt), 32'h6);
        cyc();
        bus.br_taken = 1'b0;
        #1;
        check("drain_pc",    bus.pc,            32'h100);
        check("drain_addr",  bus.imem_addr,     32'h18);
        check("drain_req",   32'(bus.imem_req), 32'h1);
        check("drain_valid", 32'(bus.if_valid), 32'h0);
        cyc();
        ack_raw = 1'b1;
        #1;
        check("dack_addr",  bus.imem_addr,     32'h18);
        check("dack_wpcir", 32'(bus.wpcir),    32'h0);
        check("dack_valid", 32'(bus.if_valid), 32'h0);
        cyc();
        ack_raw = 1'b0;
        ack_tie = 1'b1;
        exp_inst.push_back(iw(32'h100));
        #1;
        check("refetch_addr",  bus.imem_addr,     32'h100);
        check("refetch_valid", 32'(bus.if_valid), 32'h0);
        check("refetch_req",   32'(bus.imem_req), 32'h1);

        // Redirect coincident with ack: old data discarded, consume counted
        cyc();
        exp_addr.push_back(32'h104);
        exp_addr.push_back(32'h200);
        bus.br_taken  = 1'b1;
        bus.br_target = 32'h200;
        #1;
        check("co_inst",  bus.inst,         iw(32'h100));
        check("co_wpcir", 32'(bus.wpcir),   32'h1);
        cyc();
        bus.br_taken = 1'b0;
        #1;
        check("co_cnt",   32'(bus.fetch_cnt), 32'h7);
        check("co_valid", 32'(bus.if_valid),  32'h0);
        check("co_pc",    bus.pc,             32'h200);
        check("co_addr",  bus.imem_addr,      32'h200);
        cyc();
        exp_inst.push_back(iw(32'h200));
        ack_tie = 1'b0;
        ack_raw = 1'b0;
        #1;
        check("c22_inst", bus.inst,      iw(32'h200));
        check("c22_addr", bus.imem_addr, 32'h204);

        // Redirects during drain: last one wins, then reset mid-drain
        cyc();
        bus.br_taken  = 1'b1;
        bus.br_target = 32'h3F1;
        #1 check("c23_cnt", 32'(bus.fetch_cnt), 32'h8);
        cyc();
        bus.br_target = 32'h202;
        #1;
        check("d2_pc",    bus.pc,         32'h3F0);
        check("d2_wpcir", 32'(bus.wpcir), 32'h1);
        cyc();
        bus.br_taken = 1'b0;
        #1;
        check("d3_pc",   bus.pc,            32'h200);
        check("d3_addr", bus.imem_addr,     32'h204);
        check("d3_req",  32'(bus.imem_req), 32'h1);
        clrn = 1'b0;
        #1;
        chk_reset("midrst");

        // Refetch from RESET_PC after reset release
        cyc();
        cyc();
        exp_addr.push_back(32'h0);
        ack_tie = 1'b1;
        clrn    = 1'b1;
        #1 check("r1_req", 32'(bus.imem_req), 32'h0);
        cyc();
        check("r2_req",  32'(bus.imem_req), 32'h1);
        check("r2_addr", bus.imem_addr,     32'h0);
        cyc();
        bus.id_stall = 1'b1;
        #1;
        check("r3_inst", bus.inst,           iw(32'h0));
        check("r3_pc",   bus.pc,             32'h4);
        check("r3_cnt",  32'(bus.fetch_cnt), 32'h0);
        cyc();
        check("addr_q_empty", 32'(exp_addr.size()), 32'h0);
        check("inst_q_empty", 32'(exp_inst.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_fetch_ctrl.md
PIPE_FETCH_CTRL -- requirements
Module: pipe_fetch_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset; bits [1:0] SHALL be treated as 0.
REQ-002 Parameter CNT_W, default 16, width of the delivered-instruction counter.
REQ-003 Clock and reset SHALL be exactly as decided: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 clrn  in  1  asynchronous active-low reset.
REQ-006 imem_req  out  1  fetch request to instruction memory.
REQ-007 imem_addr  out  32  registered word-aligned fetch address, stable while imem_req=1.
REQ-008 imem_ack  in  1  memory returns inst_in this cycle; ignored when imem_req=0.
REQ-009 inst_in  in  32  instruction data, valid with imem_ack.
REQ-010 br_taken  in  1  one-cycle redirect pulse from EX.
REQ-011 br_target  in  32  redirect address, sampled when br_taken=1.
REQ-012 id_stall  in  1  ID cannot accept the presented instruction this cycle.
REQ-013 inst  out  32  registered instruction presented to ID.
REQ-014 if_valid  out  1  inst is valid; consumed when if_valid=1 and id_stall=0.
REQ-015 pc  out  32  architectural next-fetch PC.
REQ-016 wpcir  out  1  PC write enable, high in every cycle pc is updated at the following edge.
REQ-017 fetch_cnt  out  CNT_W  count of instructions consumed by ID.

Function
REQ-018 FSM states SHALL be IDLE, FETCH and DRAIN, with 2-bit state encoding.
REQ-019 IDLE: all outputs are inactive.
REQ-020 IDLE SHALL transition unconditionally to FETCH after 1 cycle.
REQ-021 Buffer-free condition: free = !if_valid | !id_stall.
REQ-022 FETCH: imem_req=1 only when free=1.
REQ-023 In FETCH, imem_addr SHALL be loaded with pc on the cycle a new request starts.
REQ-024 Once asserted, imem_req SHALL stay high with imem_addr unchanged until imem_ack, regardless of id_stall; requests are never aborted.
REQ-025 FETCH, imem_ack=1, br_taken=0: on the next edge, inst<=inst_in, if_valid<=1, pc<=pc+4 (mod 2^32), and wpcir=1 this cycle.
REQ-026 FETCH, consume without ack: if_valid<=0 on the next edge.
REQ-027 Consume and ack in the same cycle SHALL load the new instruction with no bubble, giving sustained 1 instruction/cycle at zero wait states.
REQ-028 br_taken=1 has highest priority: pc<=br_target & ~3, wpcir=1, and if_valid<=0 (flush) on the next edge.
REQ-029 br_taken=1 with a request outstanding and no ack that cycle: next state SHALL be DRAIN.
REQ-030 br_taken=1 coincident with imem_ack: data SHALL be discarded, no pc+4 applied, and the FSM stays in FETCH.
REQ-031 DRAIN: imem_req=1 at the old imem_addr until imem_ack; ack data SHALL be discarded.
REQ-032 DRAIN: on imem_ack, next state SHALL be FETCH, and the new request SHALL start at the redirected pc on the following cycle.
REQ-033 br_taken in DRAIN SHALL update pc again and stay in DRAIN (last redirect wins).
REQ-034 fetch_cnt SHALL increment by 1 per consume and saturate at all-ones.
REQ-035 fetch_cnt SHALL NOT count flushed instructions.
REQ-036 A consume coincident with br_taken SHALL still be counted.
REQ-037 Latency: pc to if_valid is 2 cycles minimum (request cycle plus ack edge) at zero wait states.

Reset
REQ-038 On clrn=0, state SHALL immediately become IDLE.
REQ-039 On clrn=0: pc=RESET_PC, imem_addr=RESET_PC, inst=0, if_valid=0, imem_req=0, wpcir=0, fetch_cnt=0.
REQ-040 Reset mid-request SHALL abandon the request; the memory side tolerates imem_req dropping under reset.
REQ-041 First imem_req SHALL be asserted in the 2nd cycle after clrn rises.

Verification
REQ-042 Reset release, imem_ack tied to imem_req, id_stall=0 -> imem_addr 0,4,8,C on consecutive cycles; if_valid continuous from cycle 3; fetch_cnt=4 after 4 consumes.
REQ-043 Ack delayed 3 cycles -> imem_req and imem_addr=0x4 held for 3 cycles; pc changes only on the ack edge; wpcir high exactly 1 cycle.
REQ-044 id_stall=1 for 5 cycles with if_valid=1 -> inst held stable, at most one further fetch completed, fetch_cnt frozen.
REQ-045 br_taken with br_target=0x103 while request to 0x10 is pending -> DRAIN until ack; ack data dropped; next imem_addr=0x100; if_valid=0 throughout.
REQ-046 br_taken coincident with imem_ack -> next imem_addr=br_target; no instruction from the old address reaches inst.
REQ-047 clrn pulsed low mid-DRAIN with pc=0x200 -> outputs immediately at reset values; refetch starts at RESET_PC.
